axis_threshold_calibrator: RTL and testbench

- Auto-configures the lower/upper hysteresis thresholds of the position tracker.
- Observes the same ADC stream (signal_a = lower half of tdata), finds min/max over a 2^log_window sample window, derives center +/- margin and drives the tracker's threshold inputs.
- Sits beside the tracker on the ADC AXIS fan-out; software triggers it one-shot or runs it continuously, or overrides it manually.

---
 rtl/axis_threshold_calibrator_pkg.sv | 27 ++
 rtl/axis_threshold_calibrator_minmax.sv | 43 ++++
 rtl/axis_threshold_calibrator.sv | 163 ++++++++++++++++
 tb/tb_axis_threshold_calibrator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/axis_threshold_calibrator_pkg.sv
// Shared types and helpers for the ADC threshold calibrator.
// State encoding, sample width and saturation to the sample range.
package axis_threshold_calibrator_pkg;

    localparam int HW = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_COMPUTE = 2'd2
    } cal_state_t;

    // Clamp an HW+2-bit signed value into the signed HW-bit range.
    function automatic logic signed [HW-1:0] sat_hw(
        input logic signed [HW+1:0] v
    );
        logic [2:0] top;
        top = v[HW+1:HW-1];
        if (top == 3'b000 || top == 3'b111)
            return v[HW-1:0];
        else if (v[HW+1])
            return {1'b1, {(HW-1){1'b0}}};
        else
            return {1'b0, {(HW-1){1'b1}}};
    endfunction

endpackage

// File: rtl/axis_threshold_calibrator_minmax.sv
// Running signed min/max of accepted samples.
// The first sample after a clear loads both extremes.
module minmax_tracker
    import axis_threshold_calibrator_pkg::*;
(
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic signed [HW-1:0] i_sample,
    output logic signed [HW-1:0] o_min,
    output logic signed [HW-1:0] o_max
);

    logic                 r_have;
    logic signed [HW-1:0] r_min;
    logic signed [HW-1:0] r_max;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_have <= 1'b0;
            r_min  <= '0;
            r_max  <= '0;
        end else if (i_clear) begin
            r_have <= 1'b0;
        end else if (i_valid) begin
            r_have <= 1'b1;
            if (!r_have) begin
                r_min <= i_sample;
                r_max <= i_sample;
            end else begin
                if (i_sample < r_min)
                    r_min <= i_sample;
                if (i_sample > r_max)
                    r_max <= i_sample;
            end
        end
    end

    assign o_min = r_min;
    assign o_max = r_max;

endmodule

// File: rtl/axis_threshold_calibrator.sv
// Derives tracker hysteresis thresholds from min/max of an ADC window.
// One-shot, continuous or manual-override operation.
module axis_threshold_calibrator
    import axis_threshold_calibrator_pkg::*;
#(
    parameter int                   S_AXIS_TDATA_WIDTH = 32,
    parameter int                   MAX_LOG_WINDOW     = 20,
    parameter logic signed [HW-1:0] DEFAULT_LOWER      = -16'sd1024,
    parameter logic signed [HW-1:0] DEFAULT_UPPER      = 16'sd1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          start,
    input  logic                          continuous,
    input  logic [4:0]                    log_window,
    input  logic [3:0]                    hysteresis_shift,
    input  logic                          manual_enable,
    input  logic [HW-1:0]                 manual_lower,
    input  logic [HW-1:0]                 manual_upper,
    input  logic                          S_AXIS_tvalid,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                          S_AXIS_tready,
    output logic [HW-1:0]                 lower_threshold,
    output logic [HW-1:0]                 upper_threshold,
    output logic                          busy,
    output logic                          thresholds_valid,
    output logic                          error
);

    localparam int CW = MAX_LOG_WINDOW + 1;

    cal_state_t           r_state;
    cal_state_t           w_next;
    logic                 w_arm;
    logic [4:0]           r_log;
    logic [3:0]           r_shift;
    logic [CW-1:0]        r_cnt;
    logic signed [HW-1:0] r_cal_lo;
    logic signed [HW-1:0] r_cal_hi;
    logic [HW-1:0]        r_lower;
    logic [HW-1:0]        r_upper;
    logic                 r_busy;
    logic                 r_valid;
    logic                 r_error;

    logic                 w_accept;
    logic                 w_last;
    logic [CW-1:0]        w_target;
    logic signed [HW-1:0] w_sample;
    logic signed [HW-1:0] w_min;
    logic signed [HW-1:0] w_max;
    logic signed [HW:0]   w_sum;
    logic signed [HW:0]   w_center;
    logic [HW:0]          w_span;
    logic [HW:0]          w_margin;
    logic signed [HW+1:0] w_lo_ext;
    logic signed [HW+1:0] w_hi_ext;
    logic                 w_upd;
    logic signed [HW-1:0] w_cal_lo_nxt;
    logic signed [HW-1:0] w_cal_hi_nxt;
    logic                 w_unused;

    assign S_AXIS_tready = aresetn;
    assign w_sample      = S_AXIS_tdata[HW-1:0];
    assign w_unused      = ^S_AXIS_tdata[S_AXIS_TDATA_WIDTH-1:HW];

    assign w_accept = S_AXIS_tvalid && S_AXIS_tready
                   && (r_state == ST_ACQUIRE);
    assign w_target = (CW'(1) << r_log) - CW'(1);
    assign w_last   = w_accept && (r_cnt == w_target);

    minmax_tracker u_minmax (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .i_clear  (w_arm),
        .i_valid  (w_accept),
        .i_sample (w_sample),
        .o_min    (w_min),
        .o_max    (w_max)
    );

    always_comb begin
        w_next = r_state;
        w_arm  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_ACQUIRE;
                    w_arm  = 1'b1;
                end
            end
            ST_ACQUIRE: begin
                if (w_last)
                    w_next = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (continuous) begin
                    w_next = ST_ACQUIRE;
                    w_arm  = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Center floors toward -inf; span is the true non-negative difference.
    assign w_sum    = {w_max[HW-1], w_max} + {w_min[HW-1], w_min};
    assign w_center = w_sum >>> 1;
    assign w_span   = {w_max[HW-1], w_max} - {w_min[HW-1], w_min};
    assign w_margin = w_span >> r_shift;
    assign w_lo_ext = {w_center[HW], w_center} - {1'b0, w_margin};
    assign w_hi_ext = {w_center[HW], w_center} + {1'b0, w_margin};

    assign w_upd        = (r_state == ST_COMPUTE) && (w_margin != '0);
    assign w_cal_lo_nxt = w_upd ? sat_hw(w_lo_ext) : r_cal_lo;
    assign w_cal_hi_nxt = w_upd ? sat_hw(w_hi_ext) : r_cal_hi;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state  <= ST_IDLE;
            r_log    <= '0;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_cal_lo <= DEFAULT_LOWER;
            r_cal_hi <= DEFAULT_UPPER;
            r_lower  <= DEFAULT_LOWER;
            r_upper  <= DEFAULT_UPPER;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            if (w_arm) begin
                r_log   <= (log_window > 5'(MAX_LOG_WINDOW))
                         ? 5'(MAX_LOG_WINDOW) : log_window;
                r_shift <= hysteresis_shift;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == ST_COMPUTE) begin
                r_error <= (w_margin == '0);
                if (w_upd)
                    r_valid <= 1'b1;
            end
            r_cal_lo <= w_cal_lo_nxt;
            r_cal_hi <= w_cal_hi_nxt;
            // Mux on the next calibrated value so results land with COMPUTE exit.
            r_lower <= manual_enable ? manual_lower : w_cal_lo_nxt;
            r_upper <= manual_enable ? manual_upper : w_cal_hi_nxt;
        end
    end

    assign lower_threshold  = r_lower;
    assign upper_threshold  = r_upper;
    assign busy             = r_busy;
    assign thresholds_valid = r_valid;
    assign error            = r_error;

endmodule

// File: tb/tb_axis_threshold_calibrator.sv
// Directed bench for axis_threshold_calibrator.
// Linear stimulus with hand-computed thresholds.
module tb_axis_threshold_calibrator;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [4:0]  log_window = '0;
    logic [3:0]  hysteresis_shift = '0;
    logic        manual_enable = 1'b0;
    logic [15:0] manual_lower = '0;
    logic [15:0] manual_upper = '0;
    logic        S_AXIS_tvalid = 1'b0;
    logic [31:0] S_AXIS_tdata = '0;
    logic        S_AXIS_tready;
    logic [15:0] lower_threshold;
    logic [15:0] upper_threshold;
    logic        busy;
    logic        thresholds_valid;
    logic        error;

    int checks = 0;
    int errors = 0;

    axis_threshold_calibrator dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .start            (start),
        .continuous       (continuous),
        .log_window       (log_window),
        .hysteresis_shift (hysteresis_shift),
        .manual_enable    (manual_enable),
        .manual_lower     (manual_lower),
        .manual_upper     (manual_upper),
        .S_AXIS_tvalid    (S_AXIS_tvalid),
        .S_AXIS_tdata     (S_AXIS_tdata),
        .S_AXIS_tready    (S_AXIS_tready),
        .lower_threshold  (lower_threshold),
        .upper_threshold  (upper_threshold),
        .busy             (busy),
        .thresholds_valid (thresholds_valid),
        .error            (error)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_thr(input string tag, input int lo, input int hi);
        chk({tag, "_lo"}, int'($signed(lower_threshold)), lo);
        chk({tag, "_hi"}, int'($signed(upper_threshold)), hi);
    endtask

    task automatic arm(input int lw, input int sh);
        log_window       = 5'(lw);
        hysteresis_shift = 4'(sh);
        start            = 1'b1;
        tick();
        start            = 1'b0;
    endtask

    task automatic send(input int v);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = {16'hABCD, 16'(v)};
        tick();
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tdata  = 32'h1234_8000;
    endtask

    // Valid once every three cycles; idle data would disturb min if taken.
    task automatic send_gap(input int v);
        send(v);
        tick();
        tick();
    endtask

    initial begin
        tick();
        chk("tready_in_reset", int'(S_AXIS_tready), 0);
        tick();
        chk_thr("reset", -1024, 1024);
        chk("reset_valid", int'(thresholds_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_error", int'(error), 0);
        aresetn = 1'b1;
        tick();
        chk("tready_run", int'(S_AXIS_tready), 1);

        arm(2, 2);
        chk("busy_armed", int'(busy), 1);
        send(100);
        send(-300);
        send(500);
        send(-100);
        tick();
        tick();
        chk_thr("basic", -100, 300);
        chk("basic_valid", int'(thresholds_valid), 1);
        chk("basic_busy", int'(busy), 0);
        chk("basic_error", int'(error), 0);

        arm(3, 0);
        for (int i = 0; i < 8; i++) send(7);
        tick();
        tick();
        chk("const_error", int'(error), 1);
        chk_thr("const_hold", -100, 300);
        chk("const_valid", int'(thresholds_valid), 1);

        arm(1, 0);
        send(10);
        send(30);
        tick();
        tick();
        chk("recover_error", int'(error), 0);
        chk_thr("recover", 0, 40);

        arm(1, 0);
        send(-32768);
        send(32767);
        tick();
        tick();
        chk_thr("saturate", -32768, 32767);

        continuous = 1'b1;
        arm(4, 1);
        for (int i = 0; i < 16; i++) send_gap(i * 4);
        chk("cont_busy_gap", int'(busy), 1);
        chk_thr("cont_win1", 0, 60);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) continuous = 1'b0;
            if (i == 5) start = 1'b1;
            send_gap(100 + i);
            start = 1'b0;
            if (i == 8) chk("cont_busy_mid", int'(busy), 1);
        end
        chk_thr("cont_win2", 100, 114);
        chk("cont_idle", int'(busy), 0);

        manual_enable = 1'b1;
        manual_lower  = 16'd10;
        manual_upper  = 16'd20;
        arm(1, 0);
        chk_thr("manual_on", 10, 20);
        send(0);
        send(100);
        tick();
        tick();
        chk_thr("manual_hold", 10, 20);
        manual_enable = 1'b0;
        tick();
        chk_thr("manual_off", -50, 150);

        arm(2, 0);
        send(1);
        aresetn = 1'b0;
        tick();
        chk_thr("midreset", -1024, 1024);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_valid", int'(thresholds_valid), 0);
        aresetn = 1'b1;
        tick();
        send(999);
        chk("idle_no_start", int'(busy), 0);
        arm(1, 0);
        send(50);
        send(60);
        tick();
        tick();
        chk_thr("after_reset", 45, 65);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
